// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-requester arbiter and access sequencer for a single-port async RAM
// Purpose: grants requester A or B (round robin by default) and sequences the access
//   onto the RAM pins. Writes run setup/pulse/hold with the data bus driven in all three
//   states. Reads run enable/capture with the bus released.
// Config: define ARB_FIXED_PRI_EN to make A win every contention (B served only when A idle).
// Ports:
//   clk_in, rst_in                       clock (rising edge), async active-high reset
//   {a,b}_req_in/_wr_in/_addr_in/_wdata_in  per-requester command (sampled on the grant edge)
//   {a,b}_gnt_out / _ack_out             1-cycle pulses: command accepted / access complete
//   {a,b}_rdata_out                      read data, valid with ack, held until next read ack
//   ram_we_out, ram_en_out, ram_addr_out write strobe, read enable, address to the RAM
//   ram_data                             shared bidirectional RAM data bus
module ram_access_arbiter #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              a_req_in,
   input  logic              a_wr_in,
   input  logic [ADDR_W-1:0] a_addr_in,
   input  logic [DATA_W-1:0] a_wdata_in,
   output logic              a_gnt_out,
   output logic              a_ack_out,
   output logic [DATA_W-1:0] a_rdata_out,
   input  logic              b_req_in,
   input  logic              b_wr_in,
   input  logic [ADDR_W-1:0] b_addr_in,
   input  logic [DATA_W-1:0] b_wdata_in,
   output logic              b_gnt_out,
   output logic              b_ack_out,
   output logic [DATA_W-1:0] b_rdata_out,
   output logic              ram_we_out,
   output logic              ram_en_out,
   output logic [ADDR_W-1:0] ram_addr_out,
   inout  wire  [DATA_W-1:0] ram_data
);

   typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_EN, R_CAP} state_t;

   state_t            state_q, state_d;
   logic              grant;
   logic              pick_b;
   logic              wr_sel;
   logic              owner_b_q;
   logic              oe_q;
   logic [DATA_W-1:0] wdata_q;
`ifndef ARB_FIXED_PRI_EN
   logic              last_b_q;
`endif

   // Bus enable is a flop loaded from the next state, so it never glitches.
   assign ram_data = oe_q ? wdata_q : {DATA_W{1'bz}};

   always_comb begin
      grant   = 1'b0;
      pick_b  = 1'b0;
      wr_sel  = 1'b0;
      state_d = state_q;
`ifdef ARB_FIXED_PRI_EN
      pick_b = !a_req_in;
`else
      // On contention the requester that was not granted last time wins.
      pick_b = b_req_in && (!a_req_in || !last_b_q);
`endif
      wr_sel = pick_b ? b_wr_in : a_wr_in;
      case (state_q)
         IDLE: begin
            if (a_req_in || b_req_in) begin
               grant   = 1'b1;
               state_d = wr_sel ? W_SETUP : R_EN;
            end
         end
         W_SETUP: state_d = W_PULSE;
         W_PULSE: state_d = W_HOLD;
         W_HOLD:  state_d = IDLE;
         R_EN:    state_d = R_CAP;
         R_CAP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         owner_b_q    <= 1'b0;
         oe_q         <= 1'b0;
         wdata_q      <= '0;
         a_gnt_out    <= 1'b0;
         b_gnt_out    <= 1'b0;
         a_ack_out    <= 1'b0;
         b_ack_out    <= 1'b0;
         a_rdata_out  <= '0;
         b_rdata_out  <= '0;
         ram_we_out   <= 1'b0;
         ram_en_out   <= 1'b0;
         ram_addr_out <= '0;
`ifndef ARB_FIXED_PRI_EN
         last_b_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         a_gnt_out  <= grant && !pick_b;
         b_gnt_out  <= grant && pick_b;
         ram_we_out <= (state_d == W_PULSE);
         ram_en_out <= (state_d == R_EN) || (state_d == R_CAP);
         oe_q       <= (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);
         // Leaving the last state of either sequence completes the access.
         a_ack_out  <= ((state_q == W_HOLD) || (state_q == R_CAP)) && !owner_b_q;
         b_ack_out  <= ((state_q == W_HOLD) || (state_q == R_CAP)) && owner_b_q;
         if (grant) begin
            owner_b_q    <= pick_b;
            ram_addr_out <= pick_b ? b_addr_in : a_addr_in;
            wdata_q      <= pick_b ? b_wdata_in : a_wdata_in;
`ifndef ARB_FIXED_PRI_EN
            last_b_q     <= pick_b;
`endif
         end
         if (state_q == R_CAP) begin
            if (owner_b_q) b_rdata_out <= ram_data;
            else           a_rdata_out <= ram_data;
         end
      end
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - bench for ram_access_arbiter with schedule model and RAM model
module tb_ram_access_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        a_req_in = 1'b0, a_wr_in = 1'b0;
   logic [2:0]  a_addr_in = '0;
   logic [15:0] a_wdata_in = '0;
   logic        b_req_in = 1'b0, b_wr_in = 1'b0;
   logic [2:0]  b_addr_in = '0;
   logic [15:0] b_wdata_in = '0;
   logic        a_gnt_out, a_ack_out, b_gnt_out, b_ack_out;
   logic [15:0] a_rdata_out, b_rdata_out;
   logic        ram_we_out, ram_en_out;
   logic [2:0]  ram_addr_out;
   wire  [15:0] ram_data;

   int total = 0;
   int bad = 0;
   bit started = 0;

   ram_access_arbiter #(.ADDR_W(3), .DATA_W(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .a_req_in(a_req_in), .a_wr_in(a_wr_in), .a_addr_in(a_addr_in), .a_wdata_in(a_wdata_in),
      .a_gnt_out(a_gnt_out), .a_ack_out(a_ack_out), .a_rdata_out(a_rdata_out),
      .b_req_in(b_req_in), .b_wr_in(b_wr_in), .b_addr_in(b_addr_in), .b_wdata_in(b_wdata_in),
      .b_gnt_out(b_gnt_out), .b_ack_out(b_ack_out), .b_rdata_out(b_rdata_out),
      .ram_we_out(ram_we_out), .ram_en_out(ram_en_out), .ram_addr_out(ram_addr_out),
      .ram_data(ram_data)
   );

   always #5 clk_in = ~clk_in;

   // Environment: the asynchronous RAM itself.
   logic [15:0] ram_mem [8];
   assign ram_data = ram_en_out ? ram_mem[ram_addr_out] : 16'bz;
   always @(negedge clk_in) if (ram_we_out) ram_mem[ram_addr_out] <= ram_data;

   // Model: a schedule of the current access (start cycle, length) plus the memory contents.
   int          cyc = 0;
   bit          m_valid = 0, m_b = 0, m_wr = 0, m_last_b = 1, m_idle, m_pb;
   logic [2:0]  m_addr = '0;
   logic [15:0] m_data = '0;
   int          m_start = 0, m_ack = 0;
   logic [15:0] m_mem [8];
   logic [15:0] e_a_rdata = '0, e_b_rdata = '0;

   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         m_valid = 0;
         m_last_b = 1;
         e_a_rdata = '0;
         e_b_rdata = '0;
      end else begin
         m_idle = !m_valid || (cyc >= m_ack);
         cyc = cyc + 1;
         if (m_idle && (a_req_in || b_req_in)) begin
`ifdef ARB_FIXED_PRI_EN
            m_pb = !a_req_in;
`else
            if (a_req_in && b_req_in) m_pb = !m_last_b;
            else                      m_pb = b_req_in;
`endif
            m_last_b = m_pb;
            m_valid  = 1;
            m_b      = m_pb;
            m_wr     = m_pb ? b_wr_in : a_wr_in;
            m_addr   = m_pb ? b_addr_in : a_addr_in;
            m_data   = m_pb ? b_wdata_in : a_wdata_in;
            m_start  = cyc;
            m_ack    = cyc + (m_wr ? 3 : 2);
         end else if (m_valid && cyc == m_ack) begin
            if (m_wr)     m_mem[m_addr] = m_data;
            else if (m_b) e_b_rdata = m_mem[m_addr];
            else          e_a_rdata = m_mem[m_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
      end
   endtask

   function automatic bit bus_free(input logic [15:0] v);
      return (v === 16'bz) || (v === 16'h0000);
   endfunction

   always @(negedge clk_in) begin
      if (started && !rst_in) begin
         int o;
         bit act, e_drv, e_en;
         o     = cyc - m_start;
         act   = m_valid && (o >= 0) && (o <= (m_wr ? 3 : 2));
         e_drv = act && m_wr && (o <= 2);
         e_en  = act && !m_wr && (o <= 1);
         chk("a_gnt", a_gnt_out, act && o == 0 && !m_b);
         chk("b_gnt", b_gnt_out, act && o == 0 && m_b);
         chk("a_ack", a_ack_out, act && o == (m_wr ? 3 : 2) && !m_b);
         chk("b_ack", b_ack_out, act && o == (m_wr ? 3 : 2) && m_b);
         chk("ram_we", ram_we_out, act && m_wr && o == 1);
         chk("ram_en", ram_en_out, e_en);
         chk("we_en_excl", ram_we_out & ram_en_out, 0);
         chk("ram_addr", ram_addr_out, m_valid ? m_addr : 3'd0);
         chk("a_rdata", a_rdata_out, e_a_rdata);
         chk("b_rdata", b_rdata_out, e_b_rdata);
         if (e_drv)     chk("bus_wr", ram_data, m_data);
         else if (e_en) chk("bus_rd", ram_data, m_mem[m_addr]);
         else           chk("bus_free", bus_free(ram_data), 1);
      end
   end

   // One access for one requester; returns grant and ack cycles (-1 on timeout).
   task automatic access(input bit who_b, input bit wr, input logic [2:0] addr,
                         input logic [15:0] data, output int gc, output int ac);
      gc = -1;
      ac = -1;
      if (who_b) begin b_req_in = 1; b_wr_in = wr; b_addr_in = addr; b_wdata_in = data; end
      else       begin a_req_in = 1; a_wr_in = wr; a_addr_in = addr; a_wdata_in = data; end
      for (int i = 0; i < 20 && gc < 0; i++) begin
         @(negedge clk_in);
         if (who_b ? b_gnt_out : a_gnt_out) gc = cyc;
      end
      a_req_in = 0;
      b_req_in = 0;
      chk("gnt_seen", gc >= 0, 1);
      for (int i = 0; i < 10 && ac < 0 && gc >= 0; i++) begin
         @(negedge clk_in);
         if (who_b ? b_ack_out : a_ack_out) ac = cyc;
      end
      if (gc >= 0) chk("ack_seen", ac >= 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      #2 rst_in = 1;
      #1;
      chk("rst_we", ram_we_out, 0);
      chk("rst_en", ram_en_out, 0);
      chk("rst_addr", ram_addr_out, 0);
      chk("rst_gnt", {a_gnt_out, b_gnt_out}, 0);
      chk("rst_ack", {a_ack_out, b_ack_out}, 0);
      chk("rst_rdata", {a_rdata_out, b_rdata_out}, 0);
      chk("rst_bus", bus_free(ram_data), 1);
      @(negedge clk_in);
      rst_in = 0;
   endtask

   initial begin
      int gc, ac, pg;
      int n;
      bit seq [6];
      for (int i = 0; i < 8; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end

      // Asynchronous reset before any clock edge.
      #3 rst_in = 1;
      #1;
      chk("por_we", ram_we_out, 0);
      chk("por_en", ram_en_out, 0);
      chk("por_addr", ram_addr_out, 0);
      chk("por_out", {a_gnt_out, b_gnt_out, a_ack_out, b_ack_out}, 0);
      chk("por_rdata", {a_rdata_out, b_rdata_out}, 0);
      chk("por_bus", bus_free(ram_data), 1);
      @(negedge clk_in);
      rst_in = 0;
      started = 1;

      access(0, 1, 3'd3, 16'h00A5, gc, ac);
      chk("wr_latency", ac - gc, 3);
      access(1, 0, 3'd3, 16'h0000, gc, ac);
      chk("rd_latency", ac - gc, 2);
      chk("rd_back", b_rdata_out, 16'h00A5);

      // Sweep: back-to-back writes then reads.
      pg = 0;
      for (int i = 0; i < 8; i++) begin
         access(0, 1, 3'(i), 16'(i * 3), gc, ac);
         if (i > 0) chk("wr_period", gc - pg, 4);
         pg = gc;
      end
      for (int i = 0; i < 8; i++) begin
         access(0, 0, 3'(i), 16'h0000, gc, ac);
         if (i > 0) chk("rd_period", gc - pg, 3);
         pg = gc;
         chk("sweep_rdata", a_rdata_out, i * 3);
      end

      // Mid-write reset: abort in W_PULSE, no ack, memory untouched.
      a_req_in = 1; a_wr_in = 1; a_addr_in = 3'd5; a_wdata_in = 16'hBEEF;
      gc = -1;
      for (int i = 0; i < 20 && gc < 0; i++) begin
         @(negedge clk_in);
         if (a_gnt_out) gc = cyc;
      end
      a_req_in = 0;
      chk("mid_gnt", gc >= 0, 1);
      @(posedge clk_in);
      #1;
      chk("mid_we_pulse", ram_we_out, 1);
      rst_in = 1;
      #1;
      chk("mid_we_drop", ram_we_out, 0);
      chk("mid_bus", bus_free(ram_data), 1);
      @(negedge clk_in);
      rst_in = 0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         if (a_ack_out) n++;
      end
      chk("mid_no_ack", n, 0);
      access(0, 0, 3'd5, 16'h0000, gc, ac);
      chk("post_rst_lat", ac - gc, 2);
      chk("post_rst_data", a_rdata_out, 16'd15);

      // Contention after reset: both request writes continuously.
      do_reset();
      a_wr_in = 1; a_addr_in = 3'd1; a_wdata_in = 16'h1111;
      b_wr_in = 1; b_addr_in = 3'd2; b_wdata_in = 16'h2222;
      a_req_in = 1; b_req_in = 1;
      n = 0;
      for (int i = 0; i < 40 && n < 6; i++) begin
         @(negedge clk_in);
         if (a_gnt_out)      begin seq[n] = 0; n++; end
         else if (b_gnt_out) begin seq[n] = 1; n++; end
      end
      a_req_in = 0;
      b_req_in = 0;
      chk("cont_count", n, 6);
      for (int i = 0; i < n; i++) begin
`ifdef ARB_FIXED_PRI_EN
         chk("cont_seq", seq[i], 0);
`else
         chk("cont_seq", seq[i], i % 2);
`endif
      end
      repeat (6) @(negedge clk_in);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

endmodule
